ps2_scancode_receiver: RTL

Receives PS/2 keyboard frames and delivers make-code scancodes to the seven-segment decoding stage. It synchronises and glitch-filters the keyboard's `ps2_clk` and `ps2_data`, deserialises 11-bit frames, and checks start, stop and (optionally) parity bits. It suppresses release sequences (`F0 xx`) and discards the `E0` extended prefix. It emits each accepted make code as a held byte plus a one-cycle valid strobe, which the display path latches as its 8-bit character code.

---
 rtl/ps2_pkg.sv | 25 ++
 rtl/ps2_input_filter.sv | 56 +++++
 rtl/ps2_scancode_receiver.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/ps2_pkg.sv
// ============================================================================
// Module      : ps2_pkg
// Description : Shared types and constants for the PS/2 scancode receiver.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ps2_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } ps2_state_t;

  localparam logic [7:0] PS2_BREAK_CODE = 8'hF0;
  localparam logic [7:0] PS2_EXT_CODE   = 8'hE0;

  localparam int PS2_FILTER_LEN_DEF     = 4;
  localparam int PS2_TIMEOUT_CYCLES_DEF = 100000;

endpackage

`default_nettype wire

// File: rtl/ps2_input_filter.sv
// ============================================================================
// Module      : ps2_input_filter
// Description : Synchroniser, glitch filter and falling-edge pulse for ps2_clk.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ps2_input_filter
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN = PS2_FILTER_LEN_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic i_ps2_clk,
  output logic o_fall
);

  localparam int               CNT_W      = $clog2(FILTER_LEN + 1);
  localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(FILTER_LEN - 1);

  logic [1:0]       r_sync;
  logic             r_filt;
  logic [CNT_W-1:0] r_cnt;
  logic             r_fall;

  // Filtered level only follows the synchronised input after FILTER_LEN
  // consecutive disagreeing samples; any agreement restarts the run.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync <= 2'b11;
      r_filt <= 1'b1;
      r_cnt  <= '0;
      r_fall <= 1'b0;
    end else begin
      r_sync <= {r_sync[0], i_ps2_clk};
      r_fall <= 1'b0;
      if (r_sync[1] != r_filt) begin
        if (r_cnt == c_cnt_last) begin
          r_filt <= r_sync[1];
          r_cnt  <= '0;
          r_fall <= ~r_sync[1];
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end else begin
        r_cnt <= '0;
      end
    end
  end

  assign o_fall = r_fall;

endmodule

`default_nettype wire

// File: rtl/ps2_scancode_receiver.sv
// ============================================================================
// Module      : ps2_scancode_receiver
// Description : PS/2 frame receiver delivering make codes; drops F0 xx and E0.
//               Optional odd-parity check enabled by PS2_PARITY_CHECK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ps2_scancode_receiver
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN     = PS2_FILTER_LEN_DEF,
  parameter int TIMEOUT_CYCLES = PS2_TIMEOUT_CYCLES_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] code_out,
  output logic       code_valid,
  output logic       frame_err
);

  localparam int               TMO_W      = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMO_W-1:0] c_tmo_last = TMO_W'(TIMEOUT_CYCLES - 1);

  logic             w_sample;
  logic [1:0]       r_data_sync;
  logic             w_data;

  ps2_state_t       r_state, w_state_nxt;
  logic [2:0]       r_bit_cnt, w_bit_cnt_nxt;
  logic [7:0]       r_shift, w_shift_nxt;
  logic [TMO_W-1:0] r_tmo_cnt, w_tmo_nxt;
  logic             r_break_pending, w_break_nxt;
  logic [7:0]       r_code_out, w_code_nxt;
  logic             r_code_valid, w_valid_nxt;
  logic             r_frame_err, w_err_nxt;
  logic             w_stop_ok;

  ps2_input_filter #(
    .FILTER_LEN (FILTER_LEN)
  ) u_clk_filter (
    .clk       (clk),
    .rst       (rst),
    .i_ps2_clk (ps2_clk),
    .o_fall    (w_sample)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_data_sync <= 2'b11;
    end else begin
      r_data_sync <= {r_data_sync[0], ps2_data};
    end
  end

  assign w_data = r_data_sync[1];

`ifdef PS2_PARITY_CHECK_EN
  logic r_par_ok, w_par_ok_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_par_ok <= 1'b0;
    end else begin
      r_par_ok <= w_par_ok_nxt;
    end
  end

  always_comb begin
    w_par_ok_nxt = r_par_ok;
    if (r_state == PARITY && w_sample) begin
      w_par_ok_nxt = ^{r_shift, w_data};
    end
  end

  assign w_stop_ok = w_data & r_par_ok;
`else
  assign w_stop_ok = w_data;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state         <= IDLE;
      r_bit_cnt       <= '0;
      r_shift         <= '0;
      r_tmo_cnt       <= '0;
      r_break_pending <= 1'b0;
      r_code_out      <= 8'h00;
      r_code_valid    <= 1'b0;
      r_frame_err     <= 1'b0;
    end else begin
      r_state         <= w_state_nxt;
      r_bit_cnt       <= w_bit_cnt_nxt;
      r_shift         <= w_shift_nxt;
      r_tmo_cnt       <= w_tmo_nxt;
      r_break_pending <= w_break_nxt;
      r_code_out      <= w_code_nxt;
      r_code_valid    <= w_valid_nxt;
      r_frame_err     <= w_err_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_bit_cnt_nxt = r_bit_cnt;
    w_shift_nxt   = r_shift;
    w_tmo_nxt     = '0;
    w_break_nxt   = r_break_pending;
    w_code_nxt    = r_code_out;
    w_valid_nxt   = 1'b0;
    w_err_nxt     = 1'b0;

    if (r_state != IDLE && !w_sample) begin
      w_tmo_nxt = r_tmo_cnt + 1'b1;
    end

    case (r_state)
      IDLE: begin
        if (w_sample && !w_data) begin
          w_state_nxt   = DATA;
          w_bit_cnt_nxt = '0;
        end
      end
      DATA: begin
        if (w_sample) begin
          w_shift_nxt = {w_data, r_shift[7:1]};
          if (r_bit_cnt == 3'd7) begin
            w_state_nxt   = PARITY;
            w_bit_cnt_nxt = '0;
          end else begin
            w_bit_cnt_nxt = r_bit_cnt + 1'b1;
          end
        end
      end
      PARITY: begin
        if (w_sample) begin
          w_state_nxt = STOP;
        end
      end
      STOP: begin
        if (w_sample) begin
          w_state_nxt = IDLE;
          if (w_stop_ok) begin
            if (r_shift == PS2_BREAK_CODE) begin
              w_break_nxt = 1'b1;
            end else if (r_shift != PS2_EXT_CODE) begin
              if (r_break_pending) begin
                w_break_nxt = 1'b0;
              end else begin
                w_code_nxt  = r_shift;
                w_valid_nxt = 1'b1;
              end
            end
          end else begin
            w_err_nxt = 1'b1;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase

    // A sample event in the same cycle takes precedence over expiry.
    if (r_state != IDLE && !w_sample && r_tmo_cnt == c_tmo_last) begin
      w_state_nxt   = IDLE;
      w_bit_cnt_nxt = '0;
      w_tmo_nxt     = '0;
      w_err_nxt     = 1'b1;
    end
  end

  assign code_out   = r_code_out;
  assign code_valid = r_code_valid;
  assign frame_err  = r_frame_err;

endmodule

`default_nettype wire
